// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-expansion sequencer: streams round keys 0..10 over valid/ready, one EXPAND cycle between keys.
// Optional round-key readback store is built when KEY_STORE_EN is defined; otherwise rd_key is tied to 0.
module aes_key_sched_ctrl #(
  parameter int BYTE   = 8,
  parameter int DWORD  = 32,
  parameter int LENGTH = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LENGTH-1:0] key_in,
  output logic [DWORD-1:0]  sub_in,
  input  logic [DWORD-1:0]  sub_out,
  output logic              rk_valid,
  input  logic              rk_ready,
  output logic [LENGTH-1:0] rk_key,
  output logic [3:0]        rk_round,
  output logic              busy,
  output logic              done,
  input  logic [3:0]        rd_idx,
  output logic [LENGTH-1:0] rd_key
);

  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_EXPAND} state_t;

  state_t            state_q;
  logic [LENGTH-1:0] key_q;
  logic [LENGTH-1:0] key_d;
  logic [3:0]        round_q;
  logic              valid_q;
  logic              busy_q;
  logic              done_q;
  logic              hshk;

  // Index r yields rcon(r+1); indices above 9 never reach here.
  function automatic logic [DWORD-1:0] rcon(input logic [3:0] idx);
    logic [BYTE-1:0] rc;
    case (idx)
      4'd0:    rc = 8'h01;
      4'd1:    rc = 8'h02;
      4'd2:    rc = 8'h04;
      4'd3:    rc = 8'h08;
      4'd4:    rc = 8'h10;
      4'd5:    rc = 8'h20;
      4'd6:    rc = 8'h40;
      4'd7:    rc = 8'h80;
      4'd8:    rc = 8'h1b;
      4'd9:    rc = 8'h36;
      default: rc = '0;
    endcase
    return {rc, {(DWORD-BYTE){1'b0}}};
  endfunction

  assign sub_in = {key_q[23:0], key_q[31:24]};
  assign hshk   = (state_q == S_EMIT) && rk_ready;

  always_comb begin
    logic [DWORD-1:0] w0, w1, w2, w3;
    w0    = key_q[127:96] ^ sub_out ^ rcon(round_q);
    w1    = key_q[95:64] ^ w0;
    w2    = key_q[63:32] ^ w1;
    w3    = key_q[31:0] ^ w2;
    key_d = {w0, w1, w2, w3};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      key_q   <= '0;
      round_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            key_q   <= key_in;
            round_q <= '0;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (rk_ready) begin
            valid_q <= 1'b0;
            if (round_q == 4'd10) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              state_q <= S_EXPAND;
            end
          end
        end
        S_EXPAND: begin
          key_q   <= key_d;
          round_q <= round_q + 4'd1;
          valid_q <= 1'b1;
          state_q <= S_EMIT;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rk_valid = valid_q;
  assign rk_key   = key_q;
  assign rk_round = round_q;
  assign busy     = busy_q;
  assign done     = done_q;

`ifdef KEY_STORE_EN
  logic [LENGTH-1:0] store_q [0:10];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= 10; i++) store_q[i] <= '0;
    end else if (hshk) begin
      store_q[round_q] <= key_q;
    end
  end

  assign rd_key = (rd_idx <= 4'd10) ? store_q[rd_idx] : '0;
`else
  logic unused_rd;
  assign unused_rd = ^{rd_idx, hshk};
  assign rd_key    = '0;
`endif

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed bench for aes_key_sched_ctrl: FIPS-197 schedule, stalls, ignored start, mid-run reset, back-to-back.
module tb_aes_key_sched_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic [31:0]  sub_in;
  logic [31:0]  sub_out;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_key;
  logic [3:0]   rk_round;
  logic         busy;
  logic         done;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;

  int passes = 0;
  int total  = 0;

`ifdef KEY_STORE_EN
  localparam bit HAS_STORE = 1'b1;
`else
  localparam bit HAS_STORE = 1'b0;
`endif

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  function automatic logic [7:0] sb(input logic [7:0] b);
    return SBOX[(255 - int'(b)) * 8 +: 8];
  endfunction

  always_comb sub_out = {sb(sub_in[31:24]), sb(sub_in[23:16]), sb(sub_in[15:8]), sb(sub_in[7:0])};

  always #5 clk = ~clk;

  aes_key_sched_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in),
    .sub_in(sub_in), .sub_out(sub_out),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_key(rk_key), .rk_round(rk_round),
    .busy(busy), .done(done), .rd_idx(rd_idx), .rd_key(rd_key)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
  endtask

  // Streams rounds first..10 with rk_ready high; returns in the done cycle.
  task automatic drain(input logic [127:0] ex [11], input logic [10:0] known, input int first);
    rk_ready = 1'b1;
    for (int r = first; r <= 10; r++) begin
      chk("emit_vld", rk_valid, 1);
      chk("emit_round", rk_round, r);
      if (known[r]) chk("emit_key", rk_key, ex[r]);
      tick();
      if (r < 10) begin
        chk("expand_vld", rk_valid, 0);
        chk("expand_busy", busy, 1);
        tick();
      end
    end
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 0);
  endtask

  logic [127:0] fips [11];
  logic [127:0] k2ex [11];
  logic [127:0] held_key;
  logic [3:0]   held_rnd;
  logic         held_vld;
  int           idx, dones, stall;

  initial begin
    fips[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    for (int i = 0; i < 11; i++) k2ex[i] = '0;
    k2ex[0]  = 128'h000102030405060708090a0b0c0d0e0f;
    k2ex[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    k2ex[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    rst = 1'b1; start = 1'b0; key_in = '0; rk_ready = 1'b0; rd_idx = '0;
    tick(); tick();
    chk("rst_valid", rk_valid, 0);
    chk("rst_key", rk_key, 0);
    chk("rst_round", rk_round, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sub_in", sub_in, 0);
    chk("rst_rd_key", rd_key, 0);
    rst = 1'b0;
    tick();

    // FIPS-197 schedule with rk_ready held high
    key_in = fips[0]; start = 1'b1;
    tick();
    start = 1'b0;
    chk("fips_sub_in", sub_in, 32'hcf4f3c09);
    drain(fips, 11'h7ff, 0);
    tick();
    chk("done_one_cycle", done, 0);

    rd_idx = 4'd1;  #1; chk("rd_idx1", rd_key, HAS_STORE ? fips[1] : 128'h0);
    rd_idx = 4'd10; #1; chk("rd_idx10", rd_key, HAS_STORE ? fips[10] : 128'h0);
    rd_idx = 4'd12; #1; chk("rd_idx12", rd_key, 0);

    // Random consumer stalls of 0..5 cycles
    key_in = fips[0]; start = 1'b1;
    tick();
    start = 1'b0;
    idx = 0; dones = 0; held_vld = 1'b0; stall = $urandom_range(0, 5);
    held_key = '0; held_rnd = '0;
    for (int cyc = 0; cyc < 400 && idx < 11; cyc++) begin
      if (held_vld) begin
        chk("stall_key_stable", rk_key, held_key);
        chk("stall_round_stable", rk_round, held_rnd);
      end
      held_vld = 1'b0;
      if (rk_valid) begin
        if (stall > 0) begin
          rk_ready = 1'b0; stall--;
          held_vld = 1'b1; held_key = rk_key; held_rnd = rk_round;
        end else begin
          rk_ready = 1'b1;
          chk("stall_round", rk_round, idx);
          chk("stall_key", rk_key, fips[idx]);
          idx++;
          stall = $urandom_range(0, 5);
        end
      end else begin
        rk_ready = 1'($urandom_range(0, 1));
      end
      tick();
      if (done) dones++;
    end
    rk_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) dones++;
    end
    chk("stall_all_keys", idx, 11);
    chk("stall_one_done", dones, 1);

    // start during EMIT of round 4 must be ignored
    key_in = fips[0]; start = 1'b1;
    tick();
    start = 1'b0; rk_ready = 1'b1;
    for (int r = 0; r < 4; r++) begin tick(); tick(); end
    rk_ready = 1'b0;
    chk("ign_round4", rk_round, 4);
    key_in = 128'hffeeddccbbaa99887766554433221100; start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_round_hold", rk_round, 4);
    chk("ign_key_hold", rk_key, fips[4]);
    chk("ign_busy", busy, 1);
    drain(fips, 11'h7ff, 4);

    // Reset during EXPAND of round 6, then a fresh key
    tick();
    key_in = fips[0]; start = 1'b1;
    tick();
    start = 1'b0; rk_ready = 1'b1;
    for (int r = 0; r < 6; r++) begin tick(); tick(); end
    chk("rst6_round", rk_round, 6);
    tick();
    chk("rst6_in_expand", rk_valid, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst6_busy", busy, 0);
    chk("rst6_valid", rk_valid, 0);
    chk("rst6_key", rk_key, 0);
    chk("rst6_rd_key1", HAS_STORE ? rd_key : 128'h0, 0);
    key_in = k2ex[0]; start = 1'b1;
    tick();
    start = 1'b0;
    drain(k2ex, 11'b10000000011, 0);

    // Back-to-back: start in the done cycle
    key_in = fips[0]; start = 1'b1;
    tick();
    start = 1'b0;
    chk("b2b_valid", rk_valid, 1);
    chk("b2b_round", rk_round, 0);
    chk("b2b_key", rk_key, fips[0]);
    rd_idx = 4'd10; #1;
    chk("b2b_prev_r10", rd_key, HAS_STORE ? k2ex[10] : 128'h0);
    drain(fips, 11'h7ff, 0);
    rd_idx = 4'd1;  #1; chk("b2b_rd_idx1", rd_key, HAS_STORE ? fips[1] : 128'h0);
    rd_idx = 4'd10; #1; chk("b2b_rd_idx10", rd_key, HAS_STORE ? fips[10] : 128'h0);
    tick();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
